vga_top: RTL and testbench

Top-level bring-up block for the camera-to-monitor board: a 640x480@60 VGA color-bar generator, an SDRAM initializer/refresher with built-in write/readback self-test, and idle camera-side outputs (XCLK generation, SCCB bus parked). It sits directly on the board pins. Status LEDs report SDRAM and camera health.

---
 rtl/vga_top_pkg.sv | 59 +++++
 rtl/sdram_ctrl.sv | 178 +++++++++++++++++
 rtl/vga_top.sv | 131 +++++++++++++
 tb/tb_vga_top.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_top_pkg.sv
// Shared constants for the board bring-up top: VGA 640x480@60 timing, SDRAM command
// encodings and delays, init/refresh counts, self-test pattern and controller states.
package vga_top_pkg;

  // Horizontal timing in pixels
  localparam int unsigned HVisible   = 640;
  localparam int unsigned HFront     = 16;
  localparam int unsigned HSync      = 96;
  localparam int unsigned HBack      = 48;
  localparam int unsigned HSyncStart = HVisible + HFront;
  localparam int unsigned HSyncEnd   = HSyncStart + HSync;
  localparam int unsigned HTotal     = HSyncEnd + HBack;

  // Vertical timing in lines
  localparam int unsigned VVisible   = 480;
  localparam int unsigned VFront     = 10;
  localparam int unsigned VSync      = 2;
  localparam int unsigned VBack      = 33;
  localparam int unsigned VSyncStart = VVisible + VFront;
  localparam int unsigned VSyncEnd   = VSyncStart + VSync;
  localparam int unsigned VTotal     = VSyncEnd + VBack;

  localparam int unsigned BarWidth   = 80;

  // SDRAM commands as {ncs, nras, ncas, nwe}
  localparam logic [3:0] CmdNop = 4'b0111;
  localparam logic [3:0] CmdAct = 4'b0011;
  localparam logic [3:0] CmdRd  = 4'b0101;
  localparam logic [3:0] CmdWr  = 4'b0100;
  localparam logic [3:0] CmdPre = 4'b0010;
  localparam logic [3:0] CmdRef = 4'b0001;
  localparam logic [3:0] CmdMrs = 4'b0000;

  // CL=2, BL=1, sequential burst
  localparam logic [12:0] ModeWord = 13'h020;

  // Command-to-command spacing in CLK cycles
  localparam int unsigned TRp    = 2;
  localparam int unsigned TRcd   = 2;
  localparam int unsigned TRcRef = 7;
  localparam int unsigned TMrd   = 2;

  localparam int unsigned InitWait  = 10000;
  localparam int unsigned RefPeriod = 390;

  localparam logic [15:0] PatternBase = 16'hA5A0;

  typedef enum logic [2:0] {
    StWait200,
    StPreAll,
    StRef1,
    StRef2,
    StMrs,
    StTestWr,
    StTestRd,
    StIdle
  } sd_state_e;

endpackage

// File: rtl/sdram_ctrl.sv
// SDRAM init / auto-refresh / self-test controller.
// Ports: clk_i, rst_i (async active-high); dq_io SDRAM data bus; addr_o, ba_o, clke_o,
// ncs_o/nras_o/ncas_o/nwe_o, dqm_o SDRAM pins; init_done_o (MRS issued);
// test_pass_o (sticky, all eight readback words matched).
module sdram_ctrl
  import vga_top_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  inout  wire  [15:0] dq_io,
  output logic [12:0] addr_o,
  output logic [1:0]  ba_o,
  output logic        clke_o,
  output logic        ncs_o,
  output logic        nras_o,
  output logic        ncas_o,
  output logic        nwe_o,
  output logic [1:0]  dqm_o,
  output logic        init_done_o,
  output logic        test_pass_o
);

  sd_state_e   state_q;
  logic [13:0] cnt_q;
  logic [2:0]  wait_q;
  logic [3:0]  col_q;
  logic        act_q;
  logic [8:0]  ref_cnt_q;
  logic        ref_pend_q;
  logic [3:0]  cmd_q;
  logic [12:0] addr_q;
  logic [1:0]  ba_q;
  logic [1:0]  dqm_q;
  logic        clke_q;
  logic [15:0] dq_out_q;
  logic        dq_oe_q;
  // Read-return pipeline: a read issued at edge n is compared at edge n+3
  logic [2:0]  rd_vld_q;
  logic [2:0]  rd_tag0_q, rd_tag1_q, rd_tag2_q;
  logic        init_done_q;
  logic        fail_q;
  logic        pass_q;

  assign dq_io       = dq_oe_q ? dq_out_q : 16'hzzzz;
  assign {ncs_o, nras_o, ncas_o, nwe_o} = cmd_q;
  assign addr_o      = addr_q;
  assign ba_o        = ba_q;
  assign dqm_o       = dqm_q;
  assign clke_o      = clke_q;
  assign init_done_o = init_done_q;
  assign test_pass_o = pass_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StWait200;
      cnt_q       <= '0;
      wait_q      <= '0;
      col_q       <= '0;
      act_q       <= 1'b0;
      ref_cnt_q   <= '0;
      ref_pend_q  <= 1'b0;
      cmd_q       <= CmdNop;
      addr_q      <= '0;
      ba_q        <= '0;
      dqm_q       <= 2'b11;
      clke_q      <= 1'b0;
      dq_out_q    <= '0;
      dq_oe_q     <= 1'b0;
      rd_vld_q    <= '0;
      rd_tag0_q   <= '0;
      rd_tag1_q   <= '0;
      rd_tag2_q   <= '0;
      init_done_q <= 1'b0;
      fail_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      clke_q    <= 1'b1;
      cmd_q     <= CmdNop;
      addr_q    <= '0;
      ba_q      <= '0;
      dq_oe_q   <= 1'b0;
      rd_vld_q  <= {rd_vld_q[1:0], 1'b0};
      rd_tag1_q <= rd_tag0_q;
      rd_tag2_q <= rd_tag1_q;

      if (rd_vld_q[2]) begin
        if (dq_io != PatternBase + {13'd0, rd_tag2_q}) begin
          fail_q <= 1'b1;
        end else if (rd_tag2_q == 3'd7 && !fail_q) begin
          pass_q <= 1'b1;
        end
      end

      if (wait_q != 3'd0) begin
        wait_q <= wait_q - 3'd1;
      end else begin
        unique case (state_q)
          StWait200: begin
            if (cnt_q == 14'(InitWait - 1)) state_q <= StPreAll;
            else cnt_q <= cnt_q + 14'd1;
          end
          StPreAll: begin
            cmd_q      <= CmdPre;
            addr_q[10] <= 1'b1;
            wait_q     <= 3'(TRp - 1);
            state_q    <= StRef1;
          end
          StRef1, StRef2: begin
            cmd_q   <= CmdRef;
            wait_q  <= 3'(TRcRef - 1);
            state_q <= (state_q == StRef1) ? StRef2 : StMrs;
          end
          StMrs: begin
            cmd_q       <= CmdMrs;
            addr_q      <= ModeWord;
            dqm_q       <= 2'b00;
            init_done_q <= 1'b1;
            wait_q      <= 3'(TMrd - 1);
            state_q     <= StTestWr;
          end
          StTestWr, StTestRd: begin
            if (!act_q) begin
              // Bank closed: a pending refresh is served here, between accesses
              if (ref_pend_q) begin
                cmd_q      <= CmdRef;
                ref_pend_q <= 1'b0;
                wait_q     <= 3'(TRcRef - 1);
              end else begin
                cmd_q  <= CmdAct;
                act_q  <= 1'b1;
                col_q  <= '0;
                wait_q <= 3'(TRcd - 1);
              end
            end else if (!col_q[3]) begin
              addr_q <= {10'd0, col_q[2:0]};
              col_q  <= col_q + 4'd1;
              if (state_q == StTestWr) begin
                cmd_q    <= CmdWr;
                dq_oe_q  <= 1'b1;
                dq_out_q <= PatternBase + {13'd0, col_q[2:0]};
                // Write recovery before the closing precharge
                if (col_q[2:0] == 3'd7) wait_q <= 3'd1;
              end else begin
                cmd_q       <= CmdRd;
                rd_vld_q[0] <= 1'b1;
                rd_tag0_q   <= col_q[2:0];
              end
            end else begin
              cmd_q   <= CmdPre;
              act_q   <= 1'b0;
              wait_q  <= 3'(TRp - 1);
              state_q <= (state_q == StTestWr) ? StTestRd : StIdle;
            end
          end
          StIdle: begin
            if (ref_pend_q) begin
              cmd_q      <= CmdRef;
              ref_pend_q <= 1'b0;
              wait_q     <= 3'(TRcRef - 1);
            end
          end
          default: state_q <= StWait200;
        endcase
      end

      // After the FSM so a new request landing on a service edge is kept
      if (init_done_q) begin
        if (ref_cnt_q == 9'(RefPeriod - 1)) begin
          ref_cnt_q  <= '0;
          ref_pend_q <= 1'b1;
        end else begin
          ref_cnt_q <= ref_cnt_q + 9'd1;
        end
      end
    end
  end

endmodule

// File: rtl/vga_top.sv
// Board bring-up top: 640x480@60 VGA colour bars, SDRAM init/refresh/self-test, idle camera.
// Ports: CLK 50 MHz; RSTn async active-high reset; led_o1 init done, led_o2 self-test pass,
// led_o3 toggles per cmos_vsyn rise; VGA syncs (active low) and RGB565; SDRAM pins;
// SCCB sda/sclk parked; cmos_* camera inputs; cmos_xclk = CLK/2.
module vga_top
  import vga_top_pkg::*;
(
  input  logic        CLK,
  input  logic        RSTn,
  output logic        led_o1,
  output logic        led_o2,
  output logic        led_o3,
  output logic        VSYNC_Sig,
  output logic        HSYNC_Sig,
  output logic [4:0]  Red_Sig,
  output logic [5:0]  Green_Sig,
  output logic [4:0]  Blue_Sig,
  inout  wire  [15:0] sdram_data,
  output logic [12:0] sdram_addr,
  output logic [1:0]  sdram_ba,
  output logic        sdram_clk,
  output logic        sdram_clke,
  output logic        sdram_ncs,
  output logic        sdram_nras,
  output logic        sdram_ncas,
  output logic        sdram_nwe,
  output logic [1:0]  sdram_dqm,
  inout  wire         sda,
  output logic        sclk,
  input  logic        cmos_vsyn,
  input  logic        cmos_href,
  input  logic        cmos_pclk,
  input  logic [7:0]  cmos_data,
  output logic        cmos_xclk
);

  logic       pix_en_q;
  logic [9:0] h_cnt_q, v_cnt_q;
  logic       visible;
  logic [2:0] bar;
  logic       hsync_q, vsync_q;
  logic [4:0] red_q, blue_q;
  logic [5:0] green_q;
  logic [2:0] vs_q;
  logic       led3_q, xclk_q;
  logic       unused_cam;

  assign unused_cam = ^{cmos_href, cmos_pclk, cmos_data};

  always_ff @(posedge CLK or posedge RSTn) begin
    if (RSTn) begin
      pix_en_q <= 1'b0;
      h_cnt_q  <= '0;
      v_cnt_q  <= '0;
    end else begin
      pix_en_q <= ~pix_en_q;
      if (pix_en_q) begin
        if (h_cnt_q == 10'(HTotal - 1)) begin
          h_cnt_q <= '0;
          v_cnt_q <= (v_cnt_q == 10'(VTotal - 1)) ? 10'd0 : v_cnt_q + 10'd1;
        end else begin
          h_cnt_q <= h_cnt_q + 10'd1;
        end
      end
    end
  end

  // Bar index bits map directly to channels: bit2 kills green, bit1 red, bit0 blue
  always_comb begin
    visible = (h_cnt_q < 10'(HVisible)) && (v_cnt_q < 10'(VVisible));
    bar     = 3'(h_cnt_q / 10'(BarWidth));
  end

  always_ff @(posedge CLK or posedge RSTn) begin
    if (RSTn) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
    end else begin
      hsync_q <= !(h_cnt_q >= 10'(HSyncStart) && h_cnt_q < 10'(HSyncEnd));
      vsync_q <= !(v_cnt_q >= 10'(VSyncStart) && v_cnt_q < 10'(VSyncEnd));
      red_q   <= (visible && !bar[1]) ? 5'h1F : 5'h00;
      green_q <= (visible && !bar[2]) ? 6'h3F : 6'h00;
      blue_q  <= (visible && !bar[0]) ? 5'h1F : 5'h00;
    end
  end

  assign HSYNC_Sig = hsync_q;
  assign VSYNC_Sig = vsync_q;
  assign Red_Sig   = red_q;
  assign Green_Sig = green_q;
  assign Blue_Sig  = blue_q;

  // Two sync flops then one history flop for rising-edge detect
  always_ff @(posedge CLK or posedge RSTn) begin
    if (RSTn) begin
      vs_q   <= '0;
      led3_q <= 1'b0;
      xclk_q <= 1'b0;
    end else begin
      vs_q   <= {vs_q[1:0], cmos_vsyn};
      xclk_q <= ~xclk_q;
      if (vs_q[1] && !vs_q[2]) led3_q <= ~led3_q;
    end
  end

  assign led_o3    = led3_q;
  assign cmos_xclk = xclk_q;
  assign sclk      = 1'b1;
  assign sda       = 1'bz;
  assign sdram_clk = ~CLK;

  sdram_ctrl u_sdram_ctrl (
    .clk_i       (CLK),
    .rst_i       (RSTn),
    .dq_io       (sdram_data),
    .addr_o      (sdram_addr),
    .ba_o        (sdram_ba),
    .clke_o      (sdram_clke),
    .ncs_o       (sdram_ncs),
    .nras_o      (sdram_nras),
    .ncas_o      (sdram_ncas),
    .nwe_o       (sdram_nwe),
    .dqm_o       (sdram_dqm),
    .init_done_o (led_o1),
    .test_pass_o (led_o2)
  );

endmodule

// File: tb/tb_vga_top.sv
module tb_vga_top;

  localparam logic [3:0] TNop = 4'b0111;
  localparam logic [3:0] TAct = 4'b0011;
  localparam logic [3:0] TRd  = 4'b0101;
  localparam logic [3:0] TWr  = 4'b0100;
  localparam logic [3:0] TPre = 4'b0010;
  localparam logic [3:0] TRef = 4'b0001;
  localparam logic [3:0] TMrs = 4'b0000;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b1;
  logic        led_o1, led_o2, led_o3;
  logic        VSYNC_Sig, HSYNC_Sig;
  logic [4:0]  Red_Sig, Blue_Sig;
  logic [5:0]  Green_Sig;
  wire  [15:0] sdram_data;
  logic [12:0] sdram_addr;
  logic [1:0]  sdram_ba, sdram_dqm;
  logic        sdram_clk, sdram_clke, sdram_ncs, sdram_nras, sdram_ncas, sdram_nwe;
  wire         sda;
  logic        sclk;
  logic        cmos_vsyn = 1'b0;
  logic        cmos_href = 1'b0;
  logic        cmos_pclk = 1'b0;
  logic [7:0]  cmos_data = 8'h00;
  logic        cmos_xclk;

  vga_top dut (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .led_o1     (led_o1),
    .led_o2     (led_o2),
    .led_o3     (led_o3),
    .VSYNC_Sig  (VSYNC_Sig),
    .HSYNC_Sig  (HSYNC_Sig),
    .Red_Sig    (Red_Sig),
    .Green_Sig  (Green_Sig),
    .Blue_Sig   (Blue_Sig),
    .sdram_data (sdram_data),
    .sdram_addr (sdram_addr),
    .sdram_ba   (sdram_ba),
    .sdram_clk  (sdram_clk),
    .sdram_clke (sdram_clke),
    .sdram_ncs  (sdram_ncs),
    .sdram_nras (sdram_nras),
    .sdram_ncas (sdram_ncas),
    .sdram_nwe  (sdram_nwe),
    .sdram_dqm  (sdram_dqm),
    .sda        (sda),
    .sclk       (sclk),
    .cmos_vsyn  (cmos_vsyn),
    .cmos_href  (cmos_href),
    .cmos_pclk  (cmos_pclk),
    .cmos_data  (cmos_data),
    .cmos_xclk  (cmos_xclk)
  );

  always #10 CLK = ~CLK;

  logic [3:0]  cmd;
  logic [31:0] rgb;
  assign cmd = {sdram_ncs, sdram_nras, sdram_ncas, sdram_nwe};
  assign rgb = {16'd0, Red_Sig, Green_Sig, Blue_Sig};

  // Behavioural SDRAM: command sampled on the SDRAM clock rise, CL=2 read return
  logic [15:0] mem [8];
  logic        v1 = 1'b0, v2 = 1'b0, v3 = 1'b0;
  logic [15:0] d1 = '0, d2 = '0, d3 = '0;
  logic        corrupt = 1'b0;
  always @(negedge CLK) begin
    if (cmd == TWr) mem[sdram_addr[2:0]] <= sdram_data;
    v1 <= (cmd == TRd);
    d1 <= mem[sdram_addr[2:0]] ^ ((corrupt && sdram_addr[2:0] == 3'd3) ? 16'h0001 : 16'h0000);
    v2 <= v1; d2 <= d1;
    v3 <= v2; d3 <= d2;
  end
  assign sdram_data = v3 ? d3 : 16'hzzzz;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int early_cmd = 0;
  int first_fall, second_fall, hs_low, vs_low, blank_bad;
  logic hs_prev;
  logic exp_led3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
    if (cyc <= 10000 && cmd !== TNop) early_cmd++;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  function automatic logic [31:0] rgb565(input logic [4:0] r, input logic [5:0] g,
                                         input logic [4:0] b);
    return {16'd0, r, g, b};
  endfunction

  initial begin
    // ---- reset values ----
    repeat (5) @(posedge CLK);
    #1;
    chk("rst_hsync", 32'(HSYNC_Sig), 1);
    chk("rst_vsync", 32'(VSYNC_Sig), 1);
    chk("rst_rgb", rgb, 0);
    chk("rst_leds", {29'd0, led_o1, led_o2, led_o3}, 0);
    chk("rst_clke", 32'(sdram_clke), 0);
    chk("rst_dqm", 32'(sdram_dqm), 3);
    chk("rst_cmd", 32'(cmd), 32'(TNop));
    chk("rst_addr_ba", {17'd0, sdram_ba, sdram_addr}, 0);
    chk("rst_dq_hiz", 32'(sdram_data === 16'hzzzz), 1);
    chk("rst_xclk", 32'(cmos_xclk), 0);
    chk("sclk_high", 32'(sclk), 1);
    chk("sda_hiz", 32'(sda === 1'bz), 1);

    @(negedge CLK);
    RSTn = 1'b0;
    cyc = 0;

    // ---- first cycles ----
    tick();
    chk("clke_first", 32'(sdram_clke), 1);
    chk("x0_white", rgb, rgb565(5'h1F, 6'h3F, 5'h1F));
    chk("xclk_c1", 32'(cmos_xclk), 1);
    tick();
    chk("xclk_c2", 32'(cmos_xclk), 0);
    tick();
    chk("xclk_c3", 32'(cmos_xclk), 1);

    // ---- camera vsync pulses ----
    exp_led3 = 1'b0;
    for (int p = 0; p < 3; p++) begin
      cmos_vsyn = 1'b1;
      repeat (4) tick();
      cmos_vsyn = 1'b0;
      repeat (4) tick();
      exp_led3 = ~exp_led3;
      chk("led3_toggle", 32'(led_o3), 32'(exp_led3));
    end

    // ---- colour bars on line 0 ----
    wait_until(161);
    chk("x80_yellow", rgb, rgb565(5'h1F, 6'h3F, 5'h00));
    wait_until(641);
    chk("x320_magenta", rgb, rgb565(5'h1F, 6'h00, 5'h1F));
    wait_until(801);
    chk("x400_red", rgb, rgb565(5'h1F, 6'h00, 5'h00));
    wait_until(1279);
    chk("x639_black", rgb, 0);

    // ---- horizontal timing over two lines ----
    first_fall = 0; second_fall = 0; hs_low = 0; vs_low = 0; blank_bad = 0;
    hs_prev = HSYNC_Sig;
    while (cyc < 3200) begin
      tick();
      if (!HSYNC_Sig) hs_low++;
      if (hs_prev && !HSYNC_Sig) begin
        if (first_fall == 0) first_fall = cyc;
        else if (second_fall == 0) second_fall = cyc;
      end
      hs_prev = HSYNC_Sig;
      if (!VSYNC_Sig) vs_low++;
      if (((cyc >= 1281 && cyc <= 1600) || cyc >= 2881) && rgb != 0) blank_bad++;
      if (cyc == 1601) chk("line1_x0_white", rgb, rgb565(5'h1F, 6'h3F, 5'h1F));
    end
    chk("hsync_first_fall", first_fall, 1313);
    chk("hsync_period", second_fall - first_fall, 1600);
    chk("hsync_low_cycles", hs_low, 384);
    chk("vsync_high_lines0_1", vs_low, 0);
    chk("rgb_blank_zero", blank_bad, 0);

    // ---- SDRAM init sequence ----
    wait_until(10000);
    chk("init_nop_only", early_cmd, 0);
    tick();
    chk("pre_all_cmd", 32'(cmd), 32'(TPre));
    chk("pre_all_a10", 32'(sdram_addr[10]), 1);
    wait_until(10003);
    chk("ref1_cmd", 32'(cmd), 32'(TRef));
    wait_until(10010);
    chk("ref2_cmd", 32'(cmd), 32'(TRef));
    wait_until(10016);
    chk("led1_before_mrs", 32'(led_o1), 0);
    chk("dqm_before_mrs", 32'(sdram_dqm), 3);
    tick();
    chk("mrs_cmd", 32'(cmd), 32'(TMrs));
    chk("mrs_addr", 32'(sdram_addr), 32'h020);
    chk("mrs_dqm", 32'(sdram_dqm), 0);
    chk("led1_after_mrs", 32'(led_o1), 1);

    // ---- self-test write ----
    wait_until(10019);
    chk("wr_act", 32'(cmd), 32'(TAct));
    tick();
    chk("dq_hiz_nop", 32'(sdram_data === 16'hzzzz), 1);
    tick();
    chk("wr0_cmd", 32'(cmd), 32'(TWr));
    chk("wr0_data", 32'(sdram_data), 32'hA5A0);
    wait_until(10028);
    chk("wr7_data", 32'(sdram_data), 32'hA5A7);
    chk("wr7_addr", 32'(sdram_addr), 7);
    wait_until(10030);
    chk("wr_pre", 32'(cmd), 32'(TPre));
    wait_until(10032);
    chk("rd_act", 32'(cmd), 32'(TAct));
    wait_until(10034);
    chk("rd0_cmd", 32'(cmd), 32'(TRd));
    wait_until(10042);
    chk("rd_pre", 32'(cmd), 32'(TPre));
    tick();
    chk("led2_before_last", 32'(led_o2), 0);
    tick();
    chk("led2_pass", 32'(led_o2), 1);
    for (int i = 0; i < 8; i++) chk("model_word", 32'(mem[i]), 32'h0000A5A0 + 32'(i));

    // ---- periodic refresh ----
    while (cmd !== TRef && cyc < 10600) tick();
    chk("ref_first_cycle", cyc, 10408);
    tick();
    while (cmd !== TRef && cyc < 11000) tick();
    chk("ref_second_cycle", cyc, 10798);

    // ---- asynchronous reset mid-operation ----
    @(posedge CLK);
    #5;
    RSTn = 1'b1;
    #1;
    chk("arst_leds", {29'd0, led_o1, led_o2, led_o3}, 0);
    chk("arst_clke", 32'(sdram_clke), 0);
    chk("arst_cmd", 32'(cmd), 32'(TNop));
    chk("arst_dqm", 32'(sdram_dqm), 3);
    chk("arst_rgb", rgb, 0);
    chk("arst_xclk", 32'(cmos_xclk), 0);
    corrupt = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RSTn = 1'b0;
    cyc = 0;
    early_cmd = 0;

    // ---- re-init with a corrupted read word ----
    wait_until(10000);
    chk("reinit_nop_only", early_cmd, 0);
    tick();
    chk("reinit_pre_all", 32'(cmd), 32'(TPre));
    wait_until(10050);
    chk("corrupt_led1", 32'(led_o1), 1);
    chk("corrupt_led2_low", 32'(led_o2), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
